// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN at compile time to insert a parity bit (even, or odd with PARITY_ODD=1).
module uart_tx_cfg #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 done,
  output logic                 txd
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..8");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx_cfg: PARITY_ODD must be 0 or 1");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_cfg: CLK_FREQ/BAUD must be at least 2");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state, state_n;
  logic [CW-1:0]        div_cnt, div_n;
  logic [2:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, sh_n;
  logic                 txd_n, done_n;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_n;
`endif

  assign bit_end = (div_cnt == DIV_LAST);
  assign ready   = (state == IDLE);

  // NOTE: every comb output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_n = state;
    div_n   = div_cnt + CW'(1);
    bit_n   = bit_cnt;
    sh_n    = shreg;
    txd_n   = txd;
    done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif
    unique case (state)
      IDLE: begin
        div_n = '0;
        if (en) begin
          sh_n    = data;
          state_n = START;
          txd_n   = 1'b0;
          bit_n   = '0;
`ifdef UART_TX_PARITY_EN
          par_n   = (^data) ^ PARITY_ODD[0];
`endif
        end
      end
      START: begin
        if (bit_end) begin
          div_n   = '0;
          state_n = DATA;
          txd_n   = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          div_n = '0;
          sh_n  = shreg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_n   = '0;
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            txd_n   = par_q;
`else
            state_n = STOP;
            txd_n   = 1'b1;
`endif
          end else begin
            bit_n = bit_cnt + 3'd1;
            txd_n = shreg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          div_n   = '0;
          state_n = STOP;
          txd_n   = 1'b1;
        end
      end
`endif
      STOP: begin
        txd_n = 1'b1;
        if (bit_end) begin
          div_n = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_n   = '0;
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            bit_n = bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
        div_n   = '0;
        bit_n   = '0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      txd     <= 1'b1;
      done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      shreg   <= sh_n;
      txd     <= txd_n;
      done    <= done_n;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: a default-config instance and a 5-bit/2-stop/odd instance.
// Expected frames are queued at request time and checked cycle by cycle on txd.
module tb_uart_tx_cfg;

  localparam int DIV = 50000000 / 115200;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  typedef struct {
    int         sel;
    logic [7:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en0 = 1'b0, en1 = 1'b0;
  logic [7:0] data0 = '0;
  logic [4:0] data1 = '0;
  logic       ready0, done0, txd0, ready1, done1, txd1;
  logic       ready_s, done_s, txd_s;
  int         sel = 0;
  exp_t       sb[$];
  int         n_checks = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  uart_tx_cfg dut0 (
    .clk(clk), .rst(rst), .en(en0), .data(data0),
    .ready(ready0), .done(done0), .txd(txd0)
  );

  uart_tx_cfg #(.DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .data(data1),
    .ready(ready1), .done(done1), .txd(txd1)
  );

  always_comb begin
    ready_s = (sel == 0) ? ready0 : ready1;
    done_s  = (sel == 0) ? done0  : done1;
    txd_s   = (sel == 0) ? txd0   : txd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first start-bit cycle.
  task automatic drive(input int s, input logic [7:0] d, input bit hold);
    exp_t e;
    sel = s;
    check($sformatf("ready_before_req_%0h", d), ready_s, 1);
    if (s == 0) begin
      en0 = 1'b1; data0 = d;
    end else begin
      en1 = 1'b1; data1 = d[4:0];
    end
    e.sel = s;
    e.d   = (s == 0) ? d : {3'b000, d[4:0]};
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      en0 = 1'b0;
      en1 = 1'b0;
    end
  endtask

  // Checks every cycle of one frame; returns at the negedge of the done cycle.
  task automatic check_frame();
    exp_t e;
    logic bits[$];
    int   db, sbits, odd, good, busy;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e     = sb.pop_front();
    db    = (e.sel == 0) ? 8 : 5;
    sbits = (e.sel == 0) ? 1 : 2;
    odd   = (e.sel == 0) ? 0 : 1;
    bits.push_back(1'b0);
    for (int i = 0; i < db; i++) bits.push_back(e.d[i]);
    if (P == 1) bits.push_back((^e.d) ^ odd[0]);
    for (int i = 0; i < sbits; i++) bits.push_back(1'b1);
    busy = 0;
    for (int b = 0; b < bits.size(); b++) begin
      good = 0;
      for (int c = 0; c < DIV; c++) begin
        if (txd_s === bits[b]) good++;
        if (ready_s !== 1'b0 || done_s !== 1'b0) busy++;
        @(negedge clk);
      end
      check($sformatf("dut%0d_d%0h_bit%0d_cycles", e.sel, e.d, b), good, DIV);
    end
    check($sformatf("dut%0d_d%0h_busy_flags", e.sel, e.d), busy, 0);
    check($sformatf("dut%0d_d%0h_done_pulse", e.sel, e.d), done_s, 1);
    check($sformatf("dut%0d_d%0h_ready_at_done", e.sel, e.d), ready_s, 1);
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t dummy;
    int   pulses;

    // Reset with en asserted: request must not be accepted.
    en0 = 1'b1; data0 = 8'hAA;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_txd", txd0, 1);
    check("rst_ready", ready0, 1);
    check("rst_done", done0, 0);
    rst = 1'b0; en0 = 1'b0;
    @(negedge clk);
    check("post_rst_idle_txd", txd0, 1);

    // Basic frame.
    drive(0, 8'h55, 0);
    check_frame();
    @(negedge clk);
    check("basic_done_one_cycle", done0, 0);

    // Back-to-back with en held; second request presented in the done cycle.
    drive(0, 8'h55, 1);
    check_frame();
    drive(0, 8'h15, 0);
    check_frame();
    @(negedge clk);
    check("b2b_done_one_cycle", done0, 0);

    // Busy request and data change mid-frame are ignored.
    drive(0, 8'h55, 0);
    fork
      check_frame();
      begin
        repeat (1500) @(negedge clk);
        en0 = 1'b1; data0 = 8'hFF;
        @(negedge clk);
        en0 = 1'b0;
      end
    join
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) pulses++;
    end
    check("busy_extra_done", pulses, 0);
    check("busy_idle_txd", txd0, 1);

    // Mid-frame reset 1000 cycles in, then immediate new request.
    drive(0, 8'h55, 0);
    repeat (999) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_txd", txd0, 1);
    check("midrst_ready", ready0, 1);
    check("midrst_done", done0, 0);
    dummy = sb.pop_front();
    drive(0, 8'hA3, 0);
    check_frame();
    @(negedge clk);

    // Narrow width, two stop bits (odd parity if compiled in).
    drive(1, 8'h1F, 0);
    check_frame();
    @(negedge clk);
    check("w5_done_one_cycle", done1, 0);
    drive(1, 8'h0A, 0);
    check_frame();
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
